// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM.
// Decodes the registered opcode and sequences fetch/decode/execute/memory/
// writeback, driving the datapath enables and mux selects as Moore outputs.
// FETCH, MEMRD and MEMWR hold for MEM_LAT extra cycles using a wait counter.
module mips_main_control #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam int unsigned      CW  = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0]    LAT = CW'(MEM_LAT);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          wait_done;

    // The counter never exceeds LAT, so equality marks the final memory cycle.
    assign wait_done = (cnt == LAT);

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            FETCH: begin
                if (!wait_done) cnt_next = cnt + CW'(1);
                else            state_next = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (!wait_done) cnt_next = cnt + CW'(1);
                else            state_next = MEMWB;
            end
            MEMWR: begin
                if (!wait_done) cnt_next = cnt + CW'(1);
                else            state_next = FETCH;
            end
            EXECUTE:  state_next = ALUWB;
            ADDIEXEC: state_next = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // Moore outputs decoded from state; everything forced low while reset is high.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        state_o    = 4'd0;
        if (!reset) begin
            state_o = state;
            case (state)
                FETCH: begin
                    ALUSrcB = 2'b01;
                    IRWrite = wait_done;
                    PCWrite = wait_done;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (op)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                MEMADR, ADDIEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: IorD = 1'b1;
                MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ADDIWB: RegWrite = 1'b1;
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    Branch  = 1'b1;
                end
                JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_main_control.sv
// Bench for mips_main_control: table of directed vectors on a MEM_LAT=0
// instance, plus hand-written sequences on a MEM_LAT=2 instance.
// Output bundle bit order (15..0): IorD MemWrite IRWrite PCWrite Branch RegDst
// MemtoReg RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSrc[1:0] illegal_op.
module tb_mips_main_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0 = 1'b1, reset2 = 1'b1;
    logic [5:0] op0 = '0, op2 = '0;

    logic iord0, mw0, irw0, pcw0, br0, rd0, m2r0, rw0, sa0, ill0;
    logic [1:0] sb0, aop0, pcs0;
    logic [3:0] st0;
    logic iord2, mw2, irw2, pcw2, br2, rd2, m2r2, rw2, sa2, ill2;
    logic [1:0] sb2, aop2, pcs2;
    logic [3:0] st2;

    mips_main_control #(.MEM_LAT(0)) u0 (
        .clk(clk), .reset(reset0), .op(op0),
        .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0), .PCWrite(pcw0),
        .Branch(br0), .RegDst(rd0), .MemtoReg(m2r0), .RegWrite(rw0),
        .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0), .PCSrc(pcs0),
        .illegal_op(ill0), .state_o(st0)
    );

    mips_main_control #(.MEM_LAT(2)) u2 (
        .clk(clk), .reset(reset2), .op(op2),
        .IorD(iord2), .MemWrite(mw2), .IRWrite(irw2), .PCWrite(pcw2),
        .Branch(br2), .RegDst(rd2), .MemtoReg(m2r2), .RegWrite(rw2),
        .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUOp(aop2), .PCSrc(pcs2),
        .illegal_op(ill2), .state_o(st2)
    );

    logic [15:0] o0, o2;
    assign o0 = {iord0, mw0, irw0, pcw0, br0, rd0, m2r0, rw0, sa0, sb0, aop0, pcs0, ill0};
    assign o2 = {iord2, mw2, irw2, pcw2, br2, rd2, m2r2, rw2, sa2, sb2, aop2, pcs2, ill2};

    // Hand-computed expected output bundles
    localparam logic [15:0] Z    = 16'h0000;
    localparam logic [15:0] FHLD = 16'h0020; // FETCH, waiting
    localparam logic [15:0] FFIN = 16'h3020; // FETCH, final cycle
    localparam logic [15:0] DEC  = 16'h0060;
    localparam logic [15:0] DILL = 16'h0061;
    localparam logic [15:0] ADR  = 16'h00C0; // MEMADR / ADDIEXEC
    localparam logic [15:0] MRD  = 16'h8000;
    localparam logic [15:0] MWR  = 16'hC000;
    localparam logic [15:0] MWB  = 16'h0300;
    localparam logic [15:0] AWB  = 16'h0500;
    localparam logic [15:0] IWB  = 16'h0100;
    localparam logic [15:0] EXE  = 16'h0090;
    localparam logic [15:0] BRN  = 16'h088A;
    localparam logic [15:0] JMP  = 16'h1004;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [15:0] outs;
    } vec_t;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic apply(input bit sel, input logic rst, input logic [5:0] op,
                         input logic [3:0] st, input logic [15:0] outs, input string nm);
        logic [19:0] act;
        @(negedge clk);
        if (sel) begin reset2 = rst; op2 = op; end
        else     begin reset0 = rst; op0 = op; end
        #1;
        act = sel ? {st2, o2} : {st0, o0};
        n_vec++;
        if (act !== {st, outs}) begin
            n_miss++;
            $display("FAIL %s: state=%0d outs=%h, required state=%0d outs=%h",
                     nm, act[19:16], act[15:0], st, outs);
        end
    endtask

    vec_t tbl[32];

    initial begin
        tbl[0]  = '{1'b1, 6'd35, 4'd0,  Z};    // reset
        tbl[1]  = '{1'b0, 6'd35, 4'd0,  FFIN}; // LW
        tbl[2]  = '{1'b0, 6'd35, 4'd1,  DEC};
        tbl[3]  = '{1'b0, 6'd35, 4'd2,  ADR};
        tbl[4]  = '{1'b0, 6'd0,  4'd3,  MRD};  // op change in MEMRD ignored
        tbl[5]  = '{1'b0, 6'd0,  4'd4,  MWB};
        tbl[6]  = '{1'b0, 6'd0,  4'd0,  FFIN}; // R-type
        tbl[7]  = '{1'b0, 6'd0,  4'd1,  DEC};
        tbl[8]  = '{1'b0, 6'd4,  4'd6,  EXE};
        tbl[9]  = '{1'b0, 6'd4,  4'd7,  AWB};
        tbl[10] = '{1'b0, 6'd4,  4'd0,  FFIN}; // BEQ
        tbl[11] = '{1'b0, 6'd4,  4'd1,  DEC};
        tbl[12] = '{1'b0, 6'd2,  4'd8,  BRN};
        tbl[13] = '{1'b0, 6'd2,  4'd0,  FFIN}; // J
        tbl[14] = '{1'b0, 6'd2,  4'd1,  DEC};
        tbl[15] = '{1'b0, 6'd63, 4'd11, JMP};
        tbl[16] = '{1'b0, 6'd63, 4'd0,  FFIN}; // illegal
        tbl[17] = '{1'b0, 6'd63, 4'd1,  DILL};
        tbl[18] = '{1'b0, 6'd8,  4'd0,  FFIN}; // ADDI
        tbl[19] = '{1'b0, 6'd8,  4'd1,  DEC};
        tbl[20] = '{1'b0, 6'd8,  4'd9,  ADR};
        tbl[21] = '{1'b0, 6'd43, 4'd10, IWB};
        tbl[22] = '{1'b0, 6'd43, 4'd0,  FFIN}; // SW
        tbl[23] = '{1'b0, 6'd43, 4'd1,  DEC};
        tbl[24] = '{1'b0, 6'd43, 4'd2,  ADR};
        tbl[25] = '{1'b0, 6'd35, 4'd5,  MWR};
        tbl[26] = '{1'b0, 6'd35, 4'd0,  FFIN}; // LW decoded, SW in MEMADR
        tbl[27] = '{1'b0, 6'd35, 4'd1,  DEC};
        tbl[28] = '{1'b0, 6'd43, 4'd2,  ADR};
        tbl[29] = '{1'b1, 6'd43, 4'd0,  Z};    // reset during MEMWR
        tbl[30] = '{1'b0, 6'd43, 4'd0,  FFIN};
        tbl[31] = '{1'b0, 6'd43, 4'd1,  DEC};

        for (int i = 0; i < 32; i++)
            apply(1'b0, tbl[i].rst, tbl[i].op, tbl[i].st, tbl[i].outs, $sformatf("vec%0d", i));

        // MEM_LAT=2: SW with stretched FETCH and MEMWR
        apply(1'b1, 1'b1, 6'd43, 4'd0, Z,    "l2_reset");
        apply(1'b1, 1'b0, 6'd43, 4'd0, FHLD, "l2_fetch_w0");
        apply(1'b1, 1'b0, 6'd43, 4'd0, FHLD, "l2_fetch_w1");
        apply(1'b1, 1'b0, 6'd43, 4'd0, FFIN, "l2_fetch_fin");
        apply(1'b1, 1'b0, 6'd43, 4'd1, DEC,  "l2_decode");
        apply(1'b1, 1'b0, 6'd43, 4'd2, ADR,  "l2_memadr");
        apply(1'b1, 1'b0, 6'd35, 4'd5, MWR,  "l2_memwr0");
        apply(1'b1, 1'b0, 6'd35, 4'd5, MWR,  "l2_memwr1");
        apply(1'b1, 1'b0, 6'd35, 4'd5, MWR,  "l2_memwr2");
        // MEM_LAT=2: LW with stretched MEMRD
        apply(1'b1, 1'b0, 6'd35, 4'd0, FHLD, "l2_lw_fetch_w0");
        apply(1'b1, 1'b0, 6'd35, 4'd0, FHLD, "l2_lw_fetch_w1");
        apply(1'b1, 1'b0, 6'd35, 4'd0, FFIN, "l2_lw_fetch_fin");
        apply(1'b1, 1'b0, 6'd35, 4'd1, DEC,  "l2_lw_decode");
        apply(1'b1, 1'b0, 6'd35, 4'd2, ADR,  "l2_lw_memadr");
        apply(1'b1, 1'b0, 6'd35, 4'd3, MRD,  "l2_memrd0");
        apply(1'b1, 1'b0, 6'd35, 4'd3, MRD,  "l2_memrd1");
        apply(1'b1, 1'b0, 6'd35, 4'd3, MRD,  "l2_memrd2");
        apply(1'b1, 1'b0, 6'd35, 4'd4, MWB,  "l2_memwb");
        // Reset in the middle of a held FETCH clears the wait counter
        apply(1'b1, 1'b0, 6'd35, 4'd0, FHLD, "l2_fetch_pre_rst");
        apply(1'b1, 1'b1, 6'd35, 4'd0, Z,    "l2_rst_in_fetch");
        apply(1'b1, 1'b0, 6'd35, 4'd0, FHLD, "l2_after_rst_w0");
        apply(1'b1, 1'b0, 6'd35, 4'd0, FHLD, "l2_after_rst_w1");
        apply(1'b1, 1'b0, 6'd35, 4'd0, FFIN, "l2_after_rst_fin");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
